// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA FSM encoding, default sizes and the last-word index seen by the stall controller
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } dma_fsm_e;

    localparam int DMA_WORD_SIZE = 16;
    localparam int DMA_XFER_LEN  = 12;

    // The stall controller releases the pipeline when dma_state reaches this value.
    localparam logic [3:0] DMA_LAST_STATE = 4'd11;

endpackage

// File: rtl/dma_fifo.sv
// rtl/dma_fifo.sv - device-side word buffer: push/pop, full/empty flags from registered count, head word
module dma_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Flags come straight from the registered count, so a pop never frees a slot
    // for a push in the same cycle and a pushed word is visible only next cycle.
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - bus-master DMA engine (device -> memory); define DMA_IRQ_EN for a sticky done_irq
module dma_controller
    import dma_pkg::*;
#(
    parameter int WORD_SIZE  = DMA_WORD_SIZE,
    parameter int XFER_LEN   = DMA_XFER_LEN,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WORD_SIZE-1:0] cmd_addr,
    input  logic                 dev_valid,
    output logic                 dev_ready,
    input  logic [WORD_SIZE-1:0] dev_data,
    input  logic                 BG,
    output logic                 BR,
    output logic [3:0]           dma_state,
    output logic [WORD_SIZE-1:0] dma_addr,
    output logic [WORD_SIZE-1:0] dma_data,
    output logic                 dma_write,
    input  logic                 mem_ready,
    output logic                 done_irq,
    input  logic                 irq_ack
);

    localparam logic [3:0] LEN_C  = 4'(XFER_LEN);
    localparam logic [3:0] LAST_C = 4'(XFER_LEN - 1);

    dma_fsm_e             state;
    dma_fsm_e             next_state;
    logic [WORD_SIZE-1:0] base_addr;
    logic [3:0]           in_cnt;
    logic [3:0]           out_cnt;
    logic                 br_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WORD_SIZE-1:0] fifo_head;
    logic                 cmd_fire;
    logic                 dev_fire;
    logic                 commit;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign dev_fire = dev_valid & dev_ready;
    assign commit   = dma_write & mem_ready;

    dma_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (dev_fire),
        .push_data (dev_data),
        .pop       (commit),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (cmd_fire) next_state = REQ;
            REQ:  if (BG) next_state = XFER;
            XFER: if (commit && (out_cnt == LAST_C)) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        dev_ready = (state != IDLE) & ~fifo_full & (in_cnt < LEN_C);
        dma_write = (state == XFER) & BG & ~fifo_empty;
        dma_state = (state == XFER) ? out_cnt : 4'd0;
        dma_data  = (state == XFER) ? fifo_head : '0;
        dma_addr  = base_addr + {{(WORD_SIZE - 4){1'b0}}, out_cnt};
    end

    // BR is a flop of the next state so the stall controller sees a clean,
    // registered request that also drops asynchronously with reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_addr <= '0;
            in_cnt    <= 4'd0;
            out_cnt   <= 4'd0;
            br_q      <= 1'b0;
        end else begin
            br_q <= (next_state == REQ) || (next_state == XFER);
            if (cmd_fire) begin
                base_addr <= cmd_addr;
                in_cnt    <= 4'd0;
                out_cnt   <= 4'd0;
            end else begin
                if (dev_fire) in_cnt <= in_cnt + 4'd1;
                if (commit)   out_cnt <= out_cnt + 4'd1;
            end
        end
    end

    assign BR = br_q;

`ifdef DMA_IRQ_EN
    logic irq_pending;

    // Set on entry to DONE and held through DONE so an ack landing on either
    // of those cycles cannot lose a fresh completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending <= 1'b0;
        end else if ((next_state == DONE) || (state == DONE)) begin
            irq_pending <= 1'b1;
        end else if (irq_ack) begin
            irq_pending <= 1'b0;
        end
    end

    assign done_irq = irq_pending;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign done_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - directed scoreboard bench for dma_controller (both DMA_IRQ_EN builds)
module tb_dma_controller;
    import dma_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_addr = 16'h0;
    logic        dev_valid = 1'b0;
    logic        dev_ready;
    logic [15:0] dev_data = 16'h0;
    logic        BG = 1'b0;
    logic        BR;
    logic [3:0]  dma_state;
    logic [15:0] dma_addr;
    logic [15:0] dma_data;
    logic        dma_write;
    logic        mem_ready = 1'b1;
    logic        done_irq;
    logic        irq_ack = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          idx = 0;
    int          n_commits = 0;
    bit          accepted = 1'b0;
    bit          dev_en = 1'b0;
    logic [15:0] cur_base = 16'h0;
    logic [15:0] dev_seed = 16'h0;
    logic        exp_irq;
    exp_t        exp_q[$];

    dma_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .dev_data  (dev_data),
        .BG        (BG),
        .BR        (BR),
        .dma_state (dma_state),
        .dma_addr  (dma_addr),
        .dma_data  (dma_data),
        .dma_write (dma_write),
        .mem_ready (mem_ready),
        .done_irq  (done_irq),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [15:0] seed, input int i);
        return seed + 16'(i) * 16'h0101;
    endfunction

    // Device: offers words back to back; a word seen with dev_ready at the
    // falling edge is taken on the next rising edge, so its expectation is queued here.
    initial begin
        forever begin
            @(negedge clk);
            if (accepted) idx++;
            dev_valid = dev_en && (idx < 12);
            dev_data  = word_of(dev_seed, idx);
            accepted  = dev_valid && dev_ready;
            if (accepted) exp_q.push_back('{addr: cur_base + 16'(idx), data: dev_data, idx: 4'(idx)});
        end
    end

    // Memory side: every committed write must match the oldest queued word.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && dma_write && mem_ready) begin
                n_commits++;
                check("sb_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", dma_addr, e.addr);
                    check("wr_data", dma_data, e.data);
                    check("wr_state", dma_state, e.idx);
                end
            end
        end
    end

    task automatic start_xfer(input logic [15:0] base, input logic [15:0] seed);
        exp_q.delete();
        cur_base  = base;
        dev_seed  = seed;
        idx       = 0;
        accepted  = 1'b0;
        n_commits = 0;
        dev_en    = 1'b1;
        cmd_addr  = base;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("br_rise", BR, 1);
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (n_commits < 12 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_reached", 32'(n < 300), 1);
        check("done_br_low", BR, 0);
        check("done_state0", dma_state, 0);
        check("done_not_ready", cmd_ready, 0);
        check("done_irq", done_irq, exp_irq);
        check("sb_drained", exp_q.size(), 0);
        dev_en = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", cmd_ready, 1);
        check("idle_br", BR, 0);
    endtask

    initial begin
`ifdef DMA_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_br", BR, 0);
        check("rst_state", dma_state, 0);
        check("rst_write", dma_write, 0);
        check("rst_addr", dma_addr, 0);
        check("rst_data", dma_data, 0);
        check("rst_dev_ready", dev_ready, 0);
        check("rst_irq", done_irq, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic transfer, grant two cycles after BR.
        start_xfer(16'h0100, 16'h1000);
        repeat (2) begin @(posedge clk); #1; end
        BG = 1'b1;
        wait_done();
        check("basic_count", n_commits, 12);

`ifdef DMA_IRQ_EN
        repeat (3) begin @(posedge clk); #1; end
        check("irq_sticky", done_irq, 1);
        irq_ack = 1'b1;
        @(posedge clk); #1;
        irq_ack = 1'b0;
        check("irq_cleared", done_irq, 0);
`endif

        // Delayed grant: FIFO prefills to its depth, then drains back to back.
        BG = 1'b0;
        start_xfer(16'h0400, 16'h2000);
        repeat (10) begin @(posedge clk); #1; end
        check("dg_br", BR, 1);
        check("dg_fifo_fill", exp_q.size(), 4);
        check("dg_dev_ready", dev_ready, 0);
        check("dg_no_write", n_commits, 0);
        BG = 1'b1;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            check("dg_b2b_write", dma_write, 1);
        end
        wait_done();

        // Grant drop while word 5 waits, then memory stall on word 8.
        start_xfer(16'h0800, 16'h3000);
        for (int n = 0; n < 200 && n_commits < 5; n++) begin @(posedge clk); #1; end
        BG = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("gs_hold_state", dma_state, 5);
            check("gs_no_write", dma_write, 0);
            check("gs_br_held", BR, 1);
        end
        @(posedge clk); #1;
        BG = 1'b1;
        for (int n = 0; n < 200 && n_commits < 8; n++) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("ms_hold_state", dma_state, 8);
            check("ms_write_pending", dma_write, 1);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        wait_done();
        check("stall_count", n_commits, 12);

        // Address wrap; with the interrupt enabled, an ack during DONE must lose.
        start_xfer(16'hFFFA, 16'h4000);
        for (int n = 0; n < 200 && n_commits < 12; n++) begin @(posedge clk); #1; end
        irq_ack = 1'b1;
        @(posedge clk); #1;
        irq_ack = 1'b0;
        check("ack_vs_set", done_irq, exp_irq);
        dev_en = 1'b0;
        check("wrap_count", n_commits, 12);
        irq_ack = 1'b1;
        @(posedge clk); #1;
        irq_ack = 1'b0;
        check("irq_ack_clear", done_irq, 0);

        // Reset in the middle of word 7.
        start_xfer(16'h0200, 16'h5000);
        for (int n = 0; n < 200 && n_commits < 7; n++) begin @(posedge clk); #1; end
        check("mid_state7", dma_state, DMA_LAST_STATE - 4'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_br", BR, 0);
        check("mid_rst_state", dma_state, 0);
        check("mid_rst_write", dma_write, 0);
        check("mid_rst_ready", cmd_ready, 1);
        dev_en   = 1'b0;
        idx      = 0;
        accepted = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("post_rst_dev_ready", dev_ready, 0);
        start_xfer(16'h0300, 16'h6000);
        wait_done();
        check("fresh_count", n_commits, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_controller.md
# dma_controller

Bus-master DMA engine that moves a fixed-length block of words from an external device into memory, stealing the memory bus from the CPU. It sits directly upstream of the CPU hazard/stall controller. It drives the `BR` bus-request line and the 4-bit `dma_state` progress counter that the stall controller uses to hold the pipeline in its interrupt stall and release it when `dma_state` reaches 11. It also consumes the CPU's bus grant and signals completion to the CPU.

## Interface
- `WORD_SIZE`, 16: data and address width.
- `XFER_LEN`, 12: words per transfer; `dma_state` counts 0..`XFER_LEN`-1.
- `FIFO_DEPTH`, 4: device-side buffer entries (power of two).

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  CPU requests a transfer.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_addr`  in  WORD_SIZE  memory destination base address.
- `dev_valid`  in  1  device word available.
- `dev_ready`  out  1  controller accepts the device word.
- `dev_data`  in  WORD_SIZE  device word.
- `BG`  in  1  bus grant from the CPU.
- `BR`  out  1  bus request to the CPU and the stall controller.
- `dma_state`  out  4  index of the word currently on the bus.
- `dma_addr`  out  WORD_SIZE  memory write address.
- `dma_data`  out  WORD_SIZE  memory write data.
- `dma_write`  out  1  memory write strobe.
- `mem_ready`  in  1  memory accepts the write this cycle.
- `done_irq`  out  1  completion interrupt (see Configuration).
- `irq_ack`  in  1  CPU clears the pending interrupt.

## Operation
- FSM states: IDLE, REQ, XFER, DONE.
- **IDLE**
  - On command accept: latch `cmd_addr` into the address register, clear `in_cnt` and `out_cnt`, go to REQ.
- **REQ**
  - `BR`=1.
  - If `BG`=1 is sampled, go to XFER.
- **XFER**
  - `BR`=1.
  - `dma_write` = `BG` & FIFO non-empty.
  - `dma_data` = FIFO head; `dma_addr` = base + `out_cnt`.
  - A word is committed on a cycle with `dma_write & mem_ready`: pop the FIFO and increment `out_cnt`.
  - When word `XFER_LEN`-1 commits, go to DONE.
- **DONE**
  - Lasts exactly one cycle. `BR`=0, `dma_state`=0.
  - Raise the interrupt, then go to IDLE.
- `dma_state` = `out_cnt` in XFER; 0 in every other state.
- Device side:
  - `dev_ready` = (state != IDLE) & FIFO not full & (`in_cnt` < `XFER_LEN`).
  - Each accepted word increments `in_cnt`.
  - Device words are accepted from REQ onward, so the FIFO prefills before the grant arrives.
- Arithmetic:
  - `dma_addr` wraps modulo 2^WORD_SIZE.
  - The counters are 4 bits and never exceed `XFER_LEN`.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; `BR`=0; `dma_state`=0; `dma_write`=0; `dma_addr`=0; `dma_data`=0; `dev_ready`=0; `done_irq`=0; FIFO empty.
- Latency and bus request:
  - `BR` is registered and rises the cycle after command accept.
  - `BR` falls on the cycle after the last word commits.
  - The stall controller sees `dma_state`=11 during the last-word cycle and `BR`=0 on the next cycle.
- Grant:
  - First write is possible in the cycle after `BG` is sampled high in REQ.
  - If `BG` drops during XFER: `dma_write`=0, all counters hold, `BR` stays 1. The transfer resumes when `BG` returns.
- FIFO:
  - Push-to-pop latency is 1 cycle; there is no same-cycle bypass.
  - Push and pop in the same cycle are both honoured.
  - `dev_ready` uses the registered full flag, so a pop does not free a slot for a push in the same cycle.
- FIFO empty in XFER: `dma_write`=0, `dma_addr` and `dma_state` hold.
- `cmd_valid` outside IDLE is ignored; it is not queued.
- Reset mid-transfer: return to reset values immediately. `BR` falls asynchronously and the FIFO contents are discarded.

## Configuration
- `DMA_IRQ_EN` defined:
  - DONE sets a sticky `irq_pending` bit, and `done_irq` = `irq_pending`.
  - `irq_ack` clears it.
  - If a set and an ack occur in the same cycle, set wins.
- `DMA_IRQ_EN` undefined:
  - `done_irq` is tied to 0 and `irq_ack` is ignored.
  - The CPU detects completion by `cmd_ready` returning to 1.

## Structure
- Shared package `dma_pkg`:
  - FSM state enum (IDLE=0, REQ=1, XFER=2, DONE=3).
  - `WORD_SIZE` and `XFER_LEN` defaults.
  - The `DMA_LAST_STATE` constant (=11), shared with the stall controller.
- One sub-module, `dma_fifo`:
  - Synchronous FIFO, `FIFO_DEPTH` × `WORD_SIZE`.
  - Ports: push/pop; outputs full, empty and head.
  - Asynchronous active-low reset.
- The FSM, counters and address generation live in `dma_controller`.

## Test plan
- **Basic transfer:** `cmd_addr`=0x0100, device streams 12 words back to back, `BG`=1 two cycles after `BR` rises, `mem_ready`=1 → writes to 0x0100..0x010B in order, `dma_state` steps 0..11, `BR` falls the cycle after word 11.
- **Delayed grant:** `BG` held low for 10 cycles → `BR`=1 throughout, FIFO fills to 4, `dev_ready`=0, no `dma_write`; after the grant, 4 writes occur back to back.
- **Grant and memory stalls:** `BG` drops after word 5 for 3 cycles, then `mem_ready`=0 for 2 cycles at word 8 → `dma_state` holds 5 then 8, no duplicated or skipped addresses.
- **Address wrap:** `cmd_addr`=0xFFFA → addresses 0xFFFA..0xFFFF, then 0x0000..0x0005.
- **Reset mid-transfer:** `reset_n` pulsed low at `dma_state`=7 → `BR`=0 and `dma_state`=0 immediately; a new command transfers 12 fresh words.
- **`DMA_IRQ_EN` defined:** `done_irq` rises in the DONE cycle and stays high until `irq_ack`; `irq_ack` coincident with a new DONE leaves it set.
